// File: rtl/back_propagation_delta_weight_feeder.sv
// Sequencer for the hidden-1 back-propagation node: buffers NUM_DELTA deltas and
// streams (delta, weight) pairs node-major, one pair per cycle, from the weight RAM.
module back_propagation_delta_weight_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DELTA  = 24,
    parameter int NUM_NODE   = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_delta_valid,
    input  logic [DATA_WIDTH-1:0] i_delta,
    output logic                  o_ready,
    output logic                  o_weight_rd_en,
    output logic [ADDR_WIDTH-1:0] o_weight_addr,
    input  logic [DATA_WIDTH-1:0] i_weight,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_delta,
    output logic [DATA_WIDTH-1:0] o_weight,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int KW = (NUM_DELTA > 1) ? $clog2(NUM_DELTA) : 1;
    localparam int NW = (NUM_NODE > 1) ? $clog2(NUM_NODE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_DELTA - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NUM_NODE - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   load_cnt, load_cnt_nxt;
    logic [KW-1:0]   k_cnt, k_cnt_nxt;
    logic [NW-1:0]   n_cnt, n_cnt_nxt;
    logic            done_nxt;
    logic            load_wr;

    logic [DATA_WIDTH-1:0] dbuf [NUM_DELTA];
    logic                  rd_vld_p0;
    logic [KW-1:0]         k_p0;

    always_comb begin
        state_nxt    = state;
        load_cnt_nxt = load_cnt;
        k_cnt_nxt    = k_cnt;
        n_cnt_nxt    = n_cnt;
        done_nxt     = 1'b0;
        load_wr      = 1'b0;
        case (state)
            LOAD: begin
                if (i_delta_valid) begin
                    load_wr = 1'b1;
                    if (load_cnt == K_LAST) begin
                        load_cnt_nxt = '0;
                        state_nxt    = STREAM;
                    end else begin
                        load_cnt_nxt = load_cnt + KW'(1);
                    end
                end
            end
            STREAM: begin
                if (k_cnt == K_LAST) begin
                    k_cnt_nxt = '0;
                    if (n_cnt == N_LAST) begin
                        n_cnt_nxt = '0;
                        state_nxt = FLUSH;
                    end else begin
                        n_cnt_nxt = n_cnt + NW'(1);
                    end
                end else begin
                    k_cnt_nxt = k_cnt + KW'(1);
                end
            end
            FLUSH: begin
                // The last pair is on the outputs once no read remains in flight.
                if (o_valid && !rd_vld_p0) begin
                    state_nxt = LOAD;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    assign o_ready        = (state == LOAD);
    assign o_busy         = (state == STREAM) || (state == FLUSH);
    assign o_weight_rd_en = (state == STREAM);
    assign o_weight_addr  = ADDR_WIDTH'(n_cnt) * ADDR_WIDTH'(NUM_DELTA) + ADDR_WIDTH'(k_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            load_cnt  <= '0;
            k_cnt     <= '0;
            n_cnt     <= '0;
            o_done    <= 1'b0;
            rd_vld_p0 <= 1'b0;
            o_valid   <= 1'b0;
        end else begin
            state     <= state_nxt;
            load_cnt  <= load_cnt_nxt;
            k_cnt     <= k_cnt_nxt;
            n_cnt     <= n_cnt_nxt;
            o_done    <= done_nxt;
            rd_vld_p0 <= o_weight_rd_en;
            o_valid   <= rd_vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_wr) begin
            dbuf[load_cnt] <= i_delta;
        end
    end

    // p0: delta index travels alongside the outstanding RAM read
    always_ff @(posedge clk) begin
        k_p0 <= k_cnt;
    end

    // p1: RAM word and matching buffered delta become the output pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_delta  <= '0;
            o_weight <= '0;
        end else if (rd_vld_p0) begin
            o_delta  <= dbuf[k_p0];
            o_weight <= i_weight;
        end
    end
endmodule

// File: tb/tb_back_propagation_delta_weight_feeder.sv
// Randomized self-checking bench for back_propagation_delta_weight_feeder; RAM model
// returns float(address), expected pairs are derived from pair index and loaded deltas.
module tb_back_propagation_delta_weight_feeder;
    localparam int DW = 32;
    localparam int ND = 24;
    localparam int NN = 4;
    localparam int AW = 10;
    localparam int NP = ND * NN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_delta_valid = 1'b0;
    logic [DW-1:0] i_delta = '0;
    logic [DW-1:0] i_weight = '0;
    logic          o_ready, o_weight_rd_en, o_valid, o_busy, o_done;
    logic [AW-1:0] o_weight_addr;
    logic [DW-1:0] o_delta, o_weight;

    back_propagation_delta_weight_feeder #(
        .DATA_WIDTH(DW), .NUM_DELTA(ND), .NUM_NODE(NN), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_delta_valid(i_delta_valid), .i_delta(i_delta),
        .o_ready(o_ready), .o_weight_rd_en(o_weight_rd_en), .o_weight_addr(o_weight_addr),
        .i_weight(i_weight), .o_valid(o_valid), .o_delta(o_delta), .o_weight(o_weight),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_len = 0;
    int rd_cnt = 0;
    int dones = 0;
    int exp_rd_cyc = -10;
    logic [DW-1:0] exp_deltas [ND];
    logic [DW-1:0] ld_vals [ND];

    // Exact IEEE-754 single encoding of a small non-negative integer.
    function automatic logic [31:0] f2b(input int v);
        int e;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        e = 0;
        for (int b = 0; b < 31; b++) if (v[b]) e = b;
        m = 32'(v) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_weight_rd_en) i_weight <= f2b(int'(o_weight_addr));
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
            rd_cnt  = 0;
        end else begin
            chk("ready_vs_busy", 32'(o_ready), 32'(!o_busy));
            if (cyc == exp_rd_cyc) chk("ready_fall", 32'(o_ready), 32'd0);
            if (o_weight_rd_en) begin
                if (rd_cnt == 0) chk("first_rd_cycle", cyc, exp_rd_cyc);
                chk("rd_addr", 32'(o_weight_addr), rd_cnt);
                rd_cnt++;
            end
            if (o_valid) begin
                if (run_len == 0) chk("first_valid_cycle", cyc, exp_rd_cyc + 2);
                chk("valid_within_pass", 32'(run_len < NP), 32'd1);
                chk("delta", o_delta, exp_deltas[run_len % ND]);
                chk("weight", o_weight, f2b(run_len));
                chk("done_during_valid", 32'(o_done), 32'd0);
                run_len++;
            end else if (run_len > 0) begin
                chk("pass_len", run_len, NP);
                chk("done_pulse", 32'(o_done), 32'd1);
                chk("rd_count", rd_cnt, NP);
                run_len = 0;
                rd_cnt  = 0;
                dones++;
            end else begin
                chk("done_idle", 32'(o_done), 32'd0);
            end
        end
    end

    task automatic load_set(input int mode);
        int n;
        int g;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(o_ready), 32'd1);
        for (int i = 0; i < ND; i++) begin
            g = 0;
            if (i > 0 && mode == 1) g = 1;
            if (i > 0 && mode == 2) g = int'($urandom_range(0, 2));
            repeat (g) begin
                i_delta_valid = 1'b0;
                @(negedge clk);
            end
            i_delta_valid = 1'b1;
            i_delta = ld_vals[i];
            if (i == ND - 1) begin
                for (int j = 0; j < ND; j++) exp_deltas[j] = ld_vals[j];
                exp_rd_cyc = cyc + 1;
            end
            @(negedge clk);
        end
        i_delta_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (dones < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("pass_timeout", 32'(dones >= target), 32'd1);
    endtask

    task automatic ramp_vals();
        for (int i = 0; i < ND; i++) ld_vals[i] = f2b(i + 1);
    endtask

    initial begin
        int n;
        int d0;
        chk("f2b_0", f2b(0), 32'h00000000);
        chk("f2b_1", f2b(1), 32'h3F800000);
        chk("f2b_24", f2b(24), 32'h41C00000);
        chk("f2b_95", f2b(95), 32'h42BE0000);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_rd_en", 32'(o_weight_rd_en), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_addr", 32'(o_weight_addr), 32'd0);
        chk("rst_delta", o_delta, 32'd0);
        chk("rst_weight", o_weight, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // basic pass
        ramp_vals();
        chk("ramp_first", ld_vals[0], 32'h3F800000);
        chk("ramp_last", ld_vals[ND-1], 32'h41C00000);
        load_set(0);
        wait_done(1);

        // gapped load, then junk presented while streaming
        load_set(1);
        repeat (10) @(negedge clk);
        i_delta_valid = 1'b1;
        i_delta = 32'hDEADBEEF;
        repeat (30) @(negedge clk);
        i_delta_valid = 1'b0;
        wait_done(2);

        // random deltas with random gaps
        for (int i = 0; i < ND; i++) ld_vals[i] = $urandom;
        load_set(2);
        wait_done(3);

        // reset in the middle of a pass
        ramp_vals();
        load_set(0);
        n = 0;
        while (run_len < 50 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("reach_pair50", 32'(run_len >= 50), 32'd1);
        d0 = dones;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_rd_en", 32'(o_weight_rd_en), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("ready_after_release", 32'(o_ready), 32'd1);
        repeat (20) @(posedge clk);
        chk("no_done_after_abort", dones, d0);

        for (int i = 0; i < ND; i++) ld_vals[i] = $urandom;
        load_set(2);
        wait_done(d0 + 1);

        // back-to-back pass with all 2.0
        for (int i = 0; i < ND; i++) ld_vals[i] = 32'h40000000;
        load_set(0);
        wait_done(d0 + 2);
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
